// File: rtl/proc_pkg.sv
// Shared encodings for the proc_branch core: opcodes, bus selects, branch
// conditions, Tstep states and ALU operations.
package proc_pkg;

  localparam logic [2:0] OP_MV   = 3'b000;
  localparam logic [2:0] OP_BMVT = 3'b001;  // M=0 branch, M=1 mvt
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_LD   = 3'b100;
  localparam logic [2:0] OP_ST   = 3'b101;
  localparam logic [2:0] OP_AND  = 3'b110;
  localparam logic [2:0] OP_CMP  = 3'b111;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_CC = 3'b011;
  localparam logic [2:0] COND_CS = 3'b100;
  localparam logic [2:0] COND_PL = 3'b101;
  localparam logic [2:0] COND_MI = 3'b110;
  localparam logic [2:0] COND_BL = 3'b111;

  typedef enum logic [3:0] {
    SEL_R0, SEL_R1, SEL_R2, SEL_R3, SEL_R4, SEL_R5, SEL_R6, SEL_PC,
    SEL_G, SEL_D, SEL_D8, SEL_DIN
  } sel_t;

  typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5} tstep_t;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_AND} alu_op_t;

endpackage

// File: rtl/proc_alu.sv
// Combinational ALU for proc_branch: add/sub/and with {N, Z, C} flags.
// Subtract is a + ~b + 1, so C is set when no borrow occurs.
module proc_alu
  import proc_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_op_t       op,
  output logic [DW-1:0] result,
  output logic [2:0]    flags
);

  logic [DW:0] sum;

  always_comb begin
    sum = '0;
    case (op)
      ALU_ADD: sum = {1'b0, a} + {1'b0, b};
      ALU_SUB: sum = {1'b0, a} + {1'b0, ~b} + {{DW{1'b0}}, 1'b1};
      default: sum = {1'b0, a & b};
    endcase
    result = sum[DW-1:0];
    flags  = {sum[DW-1], (sum[DW-1:0] == '0), sum[DW]};
  end

endmodule

// File: rtl/proc_branch.sv
// Multi-cycle processor core with N/Z/C flags, cmp and PC-relative branches.
// Define PROC_BRANCH_BL_EN to turn condition 111 into bl (r6 <- return addr).
module proc_branch
  import proc_pkg::*;
#(
  parameter int unsigned   DW       = 16,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic [DW-1:0] DIN,
  input  logic          Run,
  output logic [DW-1:0] DOUT,
  output logic [DW-1:0] ADDR,
  output logic          W,
  output logic          Done,
  output logic [2:0]    Flags
);

`ifdef PROC_BRANCH_BL_EN
  localparam logic BL_EN = 1'b1;
`else
  localparam logic BL_EN = 1'b0;
`endif

  tstep_t        state_q, state_d;
  logic [DW-1:0] r_q [8];
  logic [DW-1:0] r_d [8];
  logic [DW-1:0] a_q, a_d, g_q, g_d, dout_q, dout_d, addr_q, addr_d;
  logic [15:0]   ir_q, ir_d;
  logic          w_q, w_d;
  logic [2:0]    flags_q, flags_d;

  sel_t          sel;
  alu_op_t       alu_op;
  logic [DW-1:0] bus, alu_res, sext_d, imm8;
  logic [2:0]    alu_flags, opc, rx, ry;
  logic          m, take, done;

  assign opc    = ir_q[15:13];
  assign m      = ir_q[12];
  assign rx     = ir_q[11:9];
  assign ry     = ir_q[2:0];
  assign sext_d = {{(DW-9){ir_q[8]}}, ir_q[8:0]};
  assign imm8   = {ir_q[7:0], {(DW-8){1'b0}}};

  // Bus source and ALU op depend only on state and IR, keeping the datapath acyclic.
  always_comb begin
    sel = SEL_G;
    case (state_q)
      T0: sel = SEL_PC;
      T3: case (opc)
        OP_MV:        sel = m ? SEL_D : sel_t'({1'b0, ry});
        OP_BMVT:      sel = m ? SEL_D8 : SEL_PC;
        OP_LD, OP_ST: sel = sel_t'({1'b0, ry});
        default:      sel = sel_t'({1'b0, rx});
      endcase
      T4: case (opc)
        OP_BMVT: sel = SEL_D;
        OP_ST:   sel = sel_t'({1'b0, rx});
        default: sel = m ? SEL_D : sel_t'({1'b0, ry});
      endcase
      T5: sel = (opc == OP_LD) ? SEL_DIN : SEL_G;
      default: sel = SEL_G;
    endcase
    case (opc)
      OP_SUB, OP_CMP: alu_op = ALU_SUB;
      OP_AND:         alu_op = ALU_AND;
      default:        alu_op = ALU_ADD;
    endcase
  end

  always_comb begin
    case (sel)
      SEL_G:   bus = g_q;
      SEL_D:   bus = sext_d;
      SEL_D8:  bus = imm8;
      SEL_DIN: bus = DIN;
      default: bus = r_q[sel[2:0]];
    endcase
  end

  always_comb begin
    case (rx)
      COND_AL: take = 1'b1;
      COND_EQ: take = flags_q[1];
      COND_NE: take = !flags_q[1];
      COND_CC: take = !flags_q[0];
      COND_CS: take = flags_q[0];
      COND_PL: take = !flags_q[2];
      COND_MI: take = flags_q[2];
      COND_BL: take = BL_EN;
      default: take = 1'b0;
    endcase
  end

  proc_alu #(.DW(DW)) u_alu (
    .a      (a_q),
    .b      (bus),
    .op     (alu_op),
    .result (alu_res),
    .flags  (alu_flags)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    a_d     = a_q;
    g_d     = g_q;
    ir_d    = ir_q;
    dout_d  = dout_q;
    addr_d  = addr_q;
    w_d     = 1'b0;
    flags_d = flags_q;
    done    = 1'b0;
    case (state_q)
      T0: begin
        addr_d = bus;
        if (Run) begin
          r_d[7]  = bus + DW'(1);
          state_d = T1;
        end
      end
      T1: state_d = T2;
      T2: begin
        ir_d    = DIN[15:0];
        state_d = T3;
      end
      T3: begin
        state_d = T4;
        case (opc)
          OP_MV: begin
            r_d[rx] = bus;
            done    = 1'b1;
          end
          OP_BMVT: begin
            if (m) begin
              r_d[rx] = bus;
              done    = 1'b1;
            end else if (take) begin
              a_d = bus;
              if (BL_EN && rx == COND_BL) r_d[6] = bus;
            end else begin
              done = 1'b1;
            end
          end
          OP_LD, OP_ST: begin
            if (m) done = 1'b1;
            else   addr_d = bus;
          end
          default: a_d = bus;
        endcase
      end
      T4: begin
        state_d = T5;
        case (opc)
          OP_BMVT: g_d = alu_res;
          OP_LD:   ;
          OP_ST: begin
            dout_d = bus;
            w_d    = 1'b1;
          end
          default: begin
            flags_d = alu_flags;
            if (opc == OP_CMP) done = 1'b1;
            else               g_d  = alu_res;
          end
        endcase
      end
      T5: begin
        done = 1'b1;
        if (opc == OP_BMVT)    r_d[7]  = bus;
        else if (opc != OP_ST) r_d[rx] = bus;
      end
      default: state_d = T0;
    endcase
    if (done) state_d = T0;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q <= T0;
      for (int unsigned i = 0; i < 7; i++) r_q[i] <= '0;
      r_q[7]  <= RESET_PC;
      a_q     <= '0;
      g_q     <= '0;
      ir_q    <= '0;
      dout_q  <= '0;
      addr_q  <= '0;
      w_q     <= 1'b0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      a_q     <= a_d;
      g_q     <= g_d;
      ir_q    <= ir_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
      w_q     <= w_d;
      flags_q <= flags_d;
    end
  end

  assign DOUT  = dout_q;
  assign ADDR  = addr_q;
  assign W     = w_q;
  assign Flags = flags_q;
  assign Done  = done;

endmodule

// File: tb/tb_proc_branch.sv
// Self-checking bench for proc_branch: program table with expected register,
// flag and cycle results, plus hand sequences for store, bl and mid-op reset.
module tb_proc_branch;
  import proc_pkg::*;

  localparam int unsigned   DW       = 16;
  localparam logic [DW-1:0] RESET_PC = '0;
`ifdef PROC_BRANCH_BL_EN
  localparam bit BL = 1'b1;
`else
  localparam bit BL = 1'b0;
`endif

  typedef struct {
    int          addr;
    logic [15:0] instr;
    int          cycles;
    int          rsel;
    logic [15:0] val;
    logic [2:0]  flags;
  } vec_t;

  logic          Clock = 1'b0;
  logic          Resetn, Run, W, Done;
  logic [DW-1:0] DIN, DOUT, ADDR;
  logic [2:0]    Flags;

  logic [DW-1:0] mem [256];
  logic          tb_we;
  logic [7:0]    tb_addr;
  logic [DW-1:0] tb_data;

  int            n_checks = 0;
  int            n_fail   = 0;
  int            w_count  = 0;
  logic [DW-1:0] w_addr, w_dout;
  vec_t          exp_q [$];

  always #5 Clock = ~Clock;

  proc_branch #(.DW(DW), .RESET_PC(RESET_PC)) dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .DIN    (DIN),
    .Run    (Run),
    .DOUT   (DOUT),
    .ADDR   (ADDR),
    .W      (W),
    .Done   (Done),
    .Flags  (Flags)
  );

  always @(posedge Clock) begin
    if (tb_we)  mem[tb_addr] <= tb_data;
    else if (W) mem[ADDR[7:0]] <= DOUT;
    DIN <= mem[ADDR[7:0]];
  end

  always @(negedge Clock) begin
    if (W) begin
      w_count++;
      w_addr = ADDR;
      w_dout = DOUT;
    end
  end

  function automatic logic [15:0] enc(input logic [2:0] op, input logic mb,
                                      input logic [2:0] x, input logic [8:0] d);
    return {op, mb, x, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic load_word(input int a, input logic [15:0] ins);
    @(negedge Clock);
    tb_we   = 1'b1;
    tb_addr = 8'(a);
    tb_data = ins;
    @(negedge Clock);
    tb_we   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_state"}, 32'(dut.state_q), 0);
    for (int i = 0; i < 7; i++) check($sformatf("%s_r%0d", tag, i), dut.r_q[i], 0);
    check({tag, "_pc"}, dut.r_q[7], RESET_PC);
    check({tag, "_a"}, dut.a_q, 0);
    check({tag, "_g"}, dut.g_q, 0);
    check({tag, "_w"}, W, 0);
    check({tag, "_addr"}, ADDR, 0);
    check({tag, "_dout"}, DOUT, 0);
    check({tag, "_flags"}, Flags, 0);
    check({tag, "_done"}, Done, 0);
  endtask

  // Starts in T0 on a negedge; returns on the negedge after Done, back in T0.
  task automatic run_vec(input vec_t v);
    int   cyc;
    vec_t e;
    exp_q.push_back(v);
    Run = 1'b1;
    cyc = 1;
    while (!Done && cyc < 12) begin
      @(negedge Clock);
      Run = 1'b0;
      cyc++;
    end
    Run = 1'b0;
    e = exp_q.pop_front();
    check($sformatf("done@%0h", e.addr), Done, 1);
    check($sformatf("cycles@%0h", e.addr), cyc, e.cycles);
    @(negedge Clock);
    check($sformatf("r%0d@%0h", e.rsel, e.addr), dut.r_q[e.rsel], e.val);
    check($sformatf("flags@%0h", e.addr), Flags, e.flags);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v [$];
    int   w0;
    Resetn = 1'b0;
    Run    = 1'b0;
    tb_we  = 1'b0;
    tb_addr = '0;
    tb_data = '0;

    v.push_back('{0,  enc(OP_MV,   1'b1, 3'd0, 9'd5),     4, 0, 16'h0005, 3'b000});
    v.push_back('{1,  enc(OP_MV,   1'b1, 3'd1, 9'd5),     4, 1, 16'h0005, 3'b000});
    v.push_back('{2,  enc(OP_CMP,  1'b0, 3'd0, 9'd1),     5, 0, 16'h0005, 3'b011});
    v.push_back('{3,  enc(OP_MV,   1'b1, 3'd2, 9'h1FF),   4, 2, 16'hFFFF, 3'b011});
    v.push_back('{4,  enc(OP_ADD,  1'b1, 3'd2, 9'd1),     6, 2, 16'h0000, 3'b011});
    v.push_back('{5,  enc(OP_BMVT, 1'b0, COND_EQ, 9'd2),  6, 7, 16'h0008, 3'b011});
    v.push_back('{8,  enc(OP_BMVT, 1'b0, COND_NE, 9'd5),  4, 7, 16'h0009, 3'b011});
    v.push_back('{9,  enc(OP_MV,   1'b1, 3'd4, 9'h040),   4, 4, 16'h0040, 3'b011});
    v.push_back('{10, enc(OP_BMVT, 1'b1, 3'd3, 9'h012),   4, 3, 16'h1200, 3'b011});
    v.push_back('{11, enc(OP_ST,   1'b0, 3'd3, 9'd4),     6, 7, 16'h000C, 3'b011});
    v.push_back('{12, enc(OP_LD,   1'b0, 3'd5, 9'd4),     6, 5, 16'h1200, 3'b011});
    v.push_back('{13, enc(OP_SUB,  1'b0, 3'd0, 9'd1),     6, 0, 16'h0000, 3'b011});
    v.push_back('{14, enc(OP_SUB,  1'b1, 3'd0, 9'd1),     6, 0, 16'hFFFF, 3'b100});
    v.push_back('{15, enc(OP_AND,  1'b1, 3'd0, 9'h0FF),   6, 0, 16'h00FF, 3'b000});
    v.push_back('{16, enc(OP_ADD,  1'b0, 3'd1, 9'd0),     6, 1, 16'h0104, 3'b000});
    v.push_back('{17, enc(OP_BMVT, 1'b0, COND_CC, 9'd1),  6, 7, 16'h0013, 3'b000});
    v.push_back('{19, enc(OP_LD,   1'b1, 3'd5, 9'd0),     4, 5, 16'h1200, 3'b000});
    v.push_back('{20, enc(OP_BMVT, 1'b0, COND_MI, 9'd3),  4, 7, 16'h0015, 3'b000});
    v.push_back('{21, enc(OP_BMVT, 1'b0, COND_PL, 9'h1FF), 6, 7, 16'h0015, 3'b000});

    foreach (v[i]) load_word(v[i].addr, v[i].instr);
    check_reset_state("por");
    Resetn = 1'b1;

    foreach (v[i]) begin
      w0 = w_count;
      run_vec(v[i]);
      if (v[i].instr[15:13] == OP_ST) begin
        check("st_wpulses", w_count - w0, 1);
        check("st_addr", w_addr, 16'h0040);
        check("st_dout", w_dout, 16'h1200);
        check("st_mem", mem[8'h40], 16'h1200);
        check("st_w_low", W, 0);
      end
    end

    // Phase 2: reset in T4 of an add, then bl / never from 0x10.
    Resetn = 1'b0;
    load_word(0,  enc(OP_MV,   1'b1, 3'd6, 9'h055));
    load_word(1,  enc(OP_ADD,  1'b1, 3'd6, 9'd1));
    load_word(2,  enc(OP_MV,   1'b1, 3'd7, 9'h010));
    load_word(16, enc(OP_BMVT, 1'b0, COND_BL, 9'h1FC));
    load_word(13, enc(OP_BMVT, 1'b0, COND_AL, 9'h1FF));
    load_word(17, enc(OP_BMVT, 1'b0, COND_AL, 9'h1FF));
    Resetn = 1'b1;

    run_vec('{0, enc(OP_MV, 1'b1, 3'd6, 9'h055), 4, 6, 16'h0055, 3'b000});
    Run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge Clock);
      Run = 1'b0;
    end
    check("pre_reset_state", 32'(dut.state_q), 4);
    Resetn = 1'b0;
    @(negedge Clock);
    check_reset_state("midrst");
    Resetn = 1'b1;
    @(negedge Clock);
    @(negedge Clock);
    check("post_rst_r6", dut.r_q[6], 0);
    check("post_rst_g", dut.g_q, 0);
    check("post_rst_state", 32'(dut.state_q), 0);

    run_vec('{0, enc(OP_MV,  1'b1, 3'd6, 9'h055), 4, 6, 16'h0055, 3'b000});
    run_vec('{1, enc(OP_ADD, 1'b1, 3'd6, 9'd1),   6, 6, 16'h0056, 3'b000});
    run_vec('{2, enc(OP_MV,  1'b1, 3'd7, 9'h010), 4, 7, 16'h0010, 3'b000});
    run_vec('{16, enc(OP_BMVT, 1'b0, COND_BL, 9'h1FC), BL ? 6 : 4, 7,
              BL ? 16'h000D : 16'h0011, 3'b000});
    check("bl_r6", dut.r_q[6], BL ? 16'h0011 : 16'h0056);
    run_vec('{BL ? 13 : 17, enc(OP_BMVT, 1'b0, COND_AL, 9'h1FF), 6, 7,
              BL ? 16'h000D : 16'h0011, 3'b000});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/proc_branch.md
Name: proc_branch

Overview:
- Parametrised next-generation multi-cycle processor core: ALU width DW, 8 registers r0..r6 plus pc (r7).
- Adds condition flags (N, Z, C), a cmp instruction and PC-relative conditional branches to the existing mv/mvt/add/sub/ld/st/and set.
- Connects to synchronous memory through DIN, ADDR, DOUT and W. The instruction word always occupies the low 16 bits of a memory word.

Parameters:
- DW, 16, data/address/register width; must be >= 16.
- RESET_PC, 0, value loaded into pc on reset.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  synchronous, active-low reset.
- DIN  in  DW  memory read data; instruction in DIN[15:0].
- Run  in  1  start fetch when high in T0.
- DOUT  out  DW  store data, registered.
- ADDR  out  DW  memory address, registered.
- W  out  1  memory write enable, registered.
- Done  out  1  high in the final cycle of each instruction (combinational from state).
- Flags  out  3  {N, Z, C}, registered.

Behaviour:
- Reset: Resetn low at a Clock edge forces:
  - state to T0;
  - r0..r6, A, G, IR, DOUT, ADDR, W and Flags to 0;
  - pc to RESET_PC.
- Reset mid-instruction aborts the instruction with no partial register writes after that edge.
- Instruction format: III M XXX DDDDDDDDD.
  - Register operand rY = IR[2:0].
  - D = IR[8:0], sign-extended to DW.
  - mvt immediate = IR[7:0] << (DW-8), low bits 0.
- States and transitions:
  - T0: ADDR <- pc; pc++ if Run. T0 -> T1 if Run, else stay in T0.
  - T1: wait.
  - T2: IR <- DIN[15:0].
  - T3, T4, T5: execute. Return to T0 when Done.
- Opcode timing:
  - mv (000): T3 rX <- rY or sext D. Done. 4 cycles.
  - mvt (0011): T3 rX <- imm. Done.
  - add/sub/and (010/011/110): T3 A <- rX; T4 G <- A op (rY or D), Flags update; T5 rX <- G, Done. 6 cycles.
  - cmp (111): as sub, but T4 updates Flags only and asserts Done. rX is unchanged. 5 cycles.
  - ld (100): T3 ADDR <- rY; T4 wait; T5 rX <- DIN, Done.
  - st (101): T3 ADDR <- rY; T4 DOUT <- rX, W_D=1; T5 Done. W is high for exactly one cycle.
  - b{cond} (0010, XXX = cond):
    - T3: if cond false, Done (4 cycles). If true, A <- pc (already incremented).
    - T4: G <- A + sext D. Flags are NOT updated.
    - T5: pc <- G, Done. Taken branch = 6 cycles.
- Condition codes:
  - 000 always; 001 eq (Z); 010 ne (!Z); 011 cc (!C); 100 cs (C); 101 pl (!N); 110 mi (N); 111 see Optional Feature.
- Flag rules, applied to the DW-bit result:
  - N = result[DW-1].
  - Z = result == 0.
  - add: C = carry out of bit DW-1.
  - sub/cmp: C = 1 when no borrow (rX >= operand, unsigned).
  - and: C cleared.
- Writing pc: any mv/mvt/add/sub/and/ld with rX=7 loads pc at the write cycle. A load overrides the increment.
- pc arithmetic wraps modulo 2^DW. Branch offset -1 from address k targets k (tight loop).
- Unused encodings (e.g. 100 1, 101 1) execute as nop: Done in T3, no state change.

Optional Feature:
- Macro PROC_BRANCH_BL_EN.
- When defined, cond 111 is bl:
  - T3 loads r6 and A with pc (return address) simultaneously.
  - T4/T5 proceed as a taken branch.
- When undefined, cond 111 means never: Done in T3, no register or flag change.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants;
  - bus Sel encodings (R0..R6, PC, G, D, D8, DIN);
  - condition-code constants;
  - Tstep state encoding T0..T5;
  - ALU op encoding.
- One sub-module, proc_alu: parametrised DW; A, B, op in; result and {N, Z, C} out; purely combinational.
- Existing regn, pc_count and dec3to8 are reused with the width parameterised.

Test Plan:
- Reset then Run: mv r0,#5; mv r1,#5; cmp r0,r1 -> Flags = {0,1,1}; r0=5; cmp completes in 5 cycles.
- mv r2,#-1; add r2,#1 (DW=16) -> r2=0x0000, Z=1, C=1, N=0.
- beq +2 with Z=1 -> pc = branch address + 3 after 6 cycles. bne with Z=1 -> falls through, Done in T3.
- mvt r3,#0x12; st r3,[r4] with r4=0x40 -> one W pulse, ADDR=0x40, DOUT=0x1200. ld r5,[r4] -> r5=0x1200.
- PROC_BRANCH_BL_EN, bl -4 at address 0x10 -> r6=0x11, pc=0x0D. Without the macro -> pc=0x11, r6 unchanged.
- Resetn low in T4 of an add -> next cycle state T0, all registers 0, pc=RESET_PC, W=0.
